// File: rtl/serial_word_driver_pkg.sv
// Shared definitions for serial_word_driver: FSM state encodings and the parity-width constant.
// SER_PARITY_EN adds one trailing parity bit to every word.
package serial_word_driver_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SHIFT_LO = 2'd1,
    S_SHIFT_HI = 2'd2,
    S_LATCH    = 2'd3
  } state_t;

`ifdef SER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/serial_word_driver_phase_tick.sv
// Phase timer for serial_word_driver: counts DIV cycles and flags the last cycle of each phase.
module phase_tick #(
  parameter int DIV = 4
) (
  input  logic CP,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(DIV - 1));

  always_ff @(posedge CP or posedge RST) begin
    if (RST)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/serial_word_driver.sv
// Serializes a parallel word MSB-first onto SD with shift strobe SCP, then pulses SLAT.
// Optional SER_PARITY_EN appends the XOR of the word as a final bit.
module serial_word_driver
  import serial_word_driver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CP,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VALID,
  output logic             READY,
  output logic             SD,
  output logic             SCP,
  output logic             SLAT,
  output logic             BUSY
);

  localparam int NBITS = WIDTH + PAR_W;
  localparam int CW    = $clog2(WIDTH + 2);

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] load;
  logic [CW-1:0]    bitcnt;
  logic             tick;

  // Timer is held cleared while idle so every transfer starts on a fresh phase.
  phase_tick #(.DIV(DIV)) u_phase (
    .CP   (CP),
    .RST  (RST),
    .clr  (state == S_IDLE),
    .tick (tick)
  );

`ifdef SER_PARITY_EN
  assign load = {DIN, ^DIN};
`else
  assign load = DIN;
`endif

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      READY  <= 1'b1;
      BUSY   <= 1'b0;
      SD     <= 1'b0;
      SCP    <= 1'b0;
      SLAT   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (VALID) begin
          shreg  <= load;
          bitcnt <= CW'(NBITS);
          SD     <= load[NBITS-1];
          SCP    <= 1'b0;
          READY  <= 1'b0;
          BUSY   <= 1'b1;
          state  <= S_SHIFT_LO;
        end
        S_SHIFT_LO: if (tick) begin
          SCP   <= 1'b1;
          state <= S_SHIFT_HI;
        end
        // SD only moves together with the SCP falling edge, keeping it stable around each rise.
        S_SHIFT_HI: if (tick) begin
          SCP    <= 1'b0;
          shreg  <= {shreg[NBITS-2:0], 1'b0};
          bitcnt <= bitcnt - CW'(1);
          if (bitcnt == CW'(1)) begin
            SD    <= 1'b0;
            SLAT  <= 1'b1;
            state <= S_LATCH;
          end else begin
            SD    <= shreg[NBITS-2];
            state <= S_SHIFT_LO;
          end
        end
        S_LATCH: if (tick) begin
          SLAT  <= 1'b0;
          READY <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_driver.sv
// Bench for serial_word_driver: three instances (DIV=2,3,1) checked cycle-by-cycle against a
// timing model derived from cycle index since accept, plus hand-computed directed expectations.
module tb_serial_word_driver;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int NB        = W + 1;
  localparam int EXP_RISES = 9;
  localparam int EXP_LOW   = 38;
  localparam int T1_BITS   = 'h14A;
  localparam int B2B_RISES = 18;
  localparam int LATCH_A   = 'hFE;
  localparam int T3_BITS   = 'h078;
`else
  localparam int NB        = W;
  localparam int EXP_RISES = 8;
  localparam int EXP_LOW   = 34;
  localparam int T1_BITS   = 'hA5;
  localparam int B2B_RISES = 16;
  localparam int LATCH_A   = 'hFF;
  localparam int T3_BITS   = 'h3C;
`endif

  logic         CP = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] DIN = '0;
  logic         VALID = 1'b0;
  logic [2:0]   ready, sd, scp, slat, busy;
  int           checks = 0;
  int           fails = 0;

  always #5 CP = ~CP;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int DV = (k == 0) ? 2 : ((k == 1) ? 3 : 1);
    serial_word_driver #(.WIDTH(W), .DIV(DV)) u_dut (
      .CP(CP), .RST(RST), .DIN(DIN), .VALID(VALID),
      .READY(ready[k]), .SD(sd[k]), .SCP(scp[k]), .SLAT(slat[k]), .BUSY(busy[k])
    );
  end

  function automatic int div_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
  endfunction

  function automatic logic [NB-1:0] bits_of(logic [W-1:0] w);
`ifdef SER_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Model: only "busy, cycles since accept, captured bits" per instance.
  bit            m_busy[3];
  int            m_c[3];
  logic [NB-1:0] m_bits[3];

  always @(posedge CP or posedge RST) begin
    for (int k = 0; k < 3; k++) begin
      if (RST) begin
        m_busy[k] <= 1'b0;
        m_c[k]    <= 0;
      end else if (!m_busy[k]) begin
        if (VALID) begin
          m_busy[k] <= 1'b1;
          m_c[k]    <= 0;
          m_bits[k] <= bits_of(DIN);
        end
      end else begin
        m_c[k] <= m_c[k] + 1;
        if (m_c[k] + 1 == 2 * div_of(k) * NB + div_of(k)) m_busy[k] <= 1'b0;
      end
    end
  end

  // {READY, BUSY, SD, SCP, SLAT} for cycle c after the accept edge.
  function automatic logic [4:0] exp_out(bit b, int c, logic [NB-1:0] bits, int dv);
    int   bi;
    logic hi;
    if (!b) return 5'b10000;
    if (c < 2 * dv * NB) begin
      bi = c / (2 * dv);
      hi = ((c % (2 * dv)) >= dv);
      return {2'b01, bits[NB-1-bi], hi, 1'b0};
    end
    return 5'b01001;
  endfunction

  // Receiving 8-stage flip-flop chain on instance 0.
  logic [W-1:0] chain;
  logic [W-1:0] latched[$];
  always @(posedge scp[0]) chain <= {chain[W-2:0], sd[0]};
  always @(posedge slat[0]) latched.push_back(chain);

  int          rises[3] = '{0, 0, 0};
  logic [31:0] hist[3] = '{32'd0, 32'd0, 32'd0};
  int          low0 = 0, hi0 = 0, slat0 = 0;
  int          age1 = 0, prev_age1 = 0;
  logic [2:0]  pscp = '0;
  logic        psd1 = 1'b0;

  task automatic cmp_loop();
    logic [4:0] e, a;
    int np = 0;
    forever begin
      @(negedge CP);
      for (int k = 0; k < 3; k++) begin
        e = exp_out(m_busy[k], m_c[k], m_bits[k], div_of(k));
        a = {ready[k], busy[k], sd[k], scp[k], slat[k]};
        checks++;
        if (a !== e) begin
          fails++;
          if (np < 20) $display("FAIL model_cmp dut%0d c=%0d got=%b want=%b", k, m_c[k], a, e);
          np++;
        end
        if (scp[k] && !pscp[k]) begin
          rises[k]++;
          hist[k] = {hist[k][30:0], sd[k]};
        end
      end
      // DIV=3 instance: SD stable 3 cycles before each rise and through the 3 high cycles.
      if (sd[1] !== psd1) age1 = 1; else age1++;
      if (scp[1] && !pscp[1]) begin
        checks++;
        if (age1 < 4) begin fails++; $display("FAIL setup_margin got_age=%0d want>=4", age1); end
      end
      if (!scp[1] && pscp[1] && busy[1]) begin
        checks++;
        if (prev_age1 < 6) begin fails++; $display("FAIL hold_margin got_age=%0d want>=6", prev_age1); end
      end
      prev_age1 = age1;
      psd1 = sd[1];
      if (!ready[0]) low0++; else hi0++;
      if (slat[0]) slat0++;
      pscp = scp;
    end
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive(logic v, logic [W-1:0] d);
    @(posedge CP);
    #2;
    VALID = v;
    DIN   = d;
  endtask

  task automatic send(logic [W-1:0] d);
    drive(1'b1, d);
    drive(1'b0, d);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (!(&ready) && n < budget) begin @(negedge CP); n++; end
    checks++;
    if (!(&ready)) begin fails++; $display("FAIL idle_timeout got=%b want=111", ready); end
    repeat (2) @(negedge CP);
  endtask

  task automatic wait_ready0(logic v, int budget);
    int n = 0;
    while (ready[0] !== v && n < budget) begin @(negedge CP); n++; end
    checks++;
    if (ready[0] !== v) begin fails++; $display("FAIL ready0_timeout got=%b want=%b", ready[0], v); end
  endtask

  initial begin
    int r0, l0, s0, h0, q0, n;
    fork cmp_loop(); join_none

    repeat (2) @(negedge CP);
    chk("reset_ready", int'(ready), 7);
    chk("reset_outs", int'({sd, scp, slat, busy}), 0);
    @(posedge CP); #2 RST = 1'b0;
    repeat (2) @(negedge CP);

    // Single word
    r0 = rises[0]; l0 = low0; s0 = slat0;
    send(8'hA5);
    wait_idle(400);
    chk("t1_rises", rises[0] - r0, EXP_RISES);
    chk("t1_bits", int'(hist[0][NB-1:0]), T1_BITS);
    chk("t1_ready_low", low0 - l0, EXP_LOW);
    chk("t1_slat_len", slat0 - s0, 2);

    // Back-to-back with VALID held high
    r0 = rises[0]; q0 = latched.size();
    drive(1'b1, 8'hFF);
    wait_ready0(1'b0, 10);
    h0 = hi0;
    drive(1'b1, 8'h00);
    wait_ready0(1'b1, 100);
    wait_ready0(1'b0, 10);
    chk("b2b_gap", hi0 - h0, 1);
    drive(1'b0, 8'h00);
    wait_idle(400);
    chk("b2b_rises", rises[0] - r0, B2B_RISES);
    chk("b2b_latches", latched.size() - q0, 2);
    if (latched.size() >= q0 + 2) begin
      chk("b2b_word0", int'(latched[q0]), LATCH_A);
      chk("b2b_word1", int'(latched[q0+1]), 0);
    end

    // Busy immunity
    r0 = rises[0];
    send(8'h3C);
    repeat (20) drive(1'($urandom_range(0, 1)), 8'hC3);
    drive(1'b0, 8'hC3);
    wait_ready0(1'b1, 100);
    chk("busy_rises", rises[0] - r0, EXP_RISES);
    chk("busy_bits", int'(hist[0][NB-1:0]), T3_BITS);
    wait_idle(400);

    // Asynchronous reset during the 4th bit
    r0 = rises[0];
    send(8'h5A);
    n = 0;
    while (rises[0] - r0 < 4 && n < 100) begin @(negedge CP); n++; end
    chk("rst_reached_bit4", rises[0] - r0, 4);
    chk("rst_pre_scp", int'(scp[0]), 1);
    #2 RST = 1'b1;
    #1;
    chk("rst_async_outs", int'({sd[0], scp[0], slat[0]}), 0);
    chk("rst_async_ready", int'(ready[0]), 1);
    repeat (2) @(negedge CP);
    #2 RST = 1'b0;
    r0 = rises[0];
    repeat (15) @(negedge CP);
    chk("rst_no_scp", rises[0] - r0, 0);
    chk("rst_idle", int'(ready), 7);

    // Word 8'h07: last bit is 1 both with parity (parity=1) and without (LSB=1)
    r0 = rises[0]; l0 = low0;
    send(8'h07);
    wait_idle(400);
    chk("w07_rises", rises[0] - r0, EXP_RISES);
    chk("w07_last_bit", int'(hist[0][0]), 1);
    chk("w07_ready_low", low0 - l0, EXP_LOW);

    // Random traffic, checked by the model every cycle
    repeat (400) drive(1'($urandom_range(0, 3) == 0), 8'($urandom));
    drive(1'b0, 8'h00);
    wait_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
